// File: rtl/number_reader.sv
// rtl/number_reader.sv - keypad number store reader: streams packed-BCD digits MSD first
//
// Purpose:
//   Captures a packed-BCD number and its digit count when start is seen in IDLE.
//   Emits the digits one per valid/ready handshake, most-significant digit first,
//   as raw BCD and as ASCII.
//
// Optional feature macro: LEADING_ZERO_SUPPRESS_EN
//   When defined, the LOAD state drops leading zero digits, one per cycle, while
//   more than one digit remains. At least one digit is always emitted.
//   When undefined, every digit of the effective count is emitted.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   capture-and-stream request, sampled in IDLE only
//   abort      in   synchronous cancel, honoured in LOAD/SEND
//   numberIn   in   packed BCD, digit 0 in bits [3:0]
//   countIn    in   number of valid digits (0 is treated as 1, clipped to NUM_DIGITS)
//   digitReady in   consumer accepts the current digit
//   digitOut   out  current BCD digit (holds its last value while not valid)
//   asciiOut   out  8'h30 + digitOut
//   digitValid out  digitOut/asciiOut/lastDigit are valid
//   lastDigit  out  current digit is the final one of the stream
//   busy       out  stream in progress (LOAD/SEND)
//   done       out  one-cycle pulse after the last digit is accepted

module number_reader #(
  parameter int NUM_DIGITS = 10,
  parameter int CNT_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [4*NUM_DIGITS-1:0] numberIn,
  input  logic [CNT_W-1:0]        countIn,
  input  logic                    digitReady,
  output logic [3:0]              digitOut,
  output logic [7:0]              asciiOut,
  output logic                    digitValid,
  output logic                    lastDigit,
  output logic                    busy,
  output logic                    done
);

  localparam int DW = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    shift_q, shift_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [3:0]       digit_q, digit_d;

  logic [CNT_W-1:0] eff;
  logic [DW-1:0]    aligned;
  logic [3:0]       top_digit;

  // Effective digit count: an empty number still produces one digit, and
  // counts beyond the store width are clipped.
  always_comb begin
    eff = countIn;
    if (countIn == '0) begin
      eff = CNT_W'(1);
    end else if (countIn > CNT_W'(NUM_DIGITS)) begin
      eff = CNT_W'(NUM_DIGITS);
    end
  end

  // Left-align at capture time so the most-significant valid digit sits in the
  // top nibble; this saves a separate capture register and LOAD then only
  // needs to settle (or, with suppression, skip zeros).
  assign aligned   = numberIn << (4 * (NUM_DIGITS - int'(eff)));
  assign top_digit = shift_q[DW-1 -: 4];

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    remaining_d = remaining_q;
    digit_d     = digit_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          shift_d     = aligned;
          remaining_d = eff;
          state_d     = S_LOAD;
        end
      end

      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
`ifdef LEADING_ZERO_SUPPRESS_EN
          if ((top_digit == 4'h0) && (remaining_q > CNT_W'(1))) begin
            shift_d     = shift_q << 4;
            remaining_d = remaining_q - CNT_W'(1);
          end else begin
            state_d = S_SEND;
          end
`else
          state_d = S_SEND;
`endif
        end
      end

      S_SEND: begin
        // Remember what is on the bus so it stays visible after the stream ends.
        digit_d = top_digit;
        if (abort) begin
          state_d = S_IDLE;
        end else if (digitReady) begin
          if (remaining_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end else begin
            shift_d     = shift_q << 4;
            remaining_d = remaining_q - CNT_W'(1);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      remaining_q <= '0;
      digit_q     <= 4'h0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      remaining_q <= remaining_d;
      digit_q     <= digit_d;
    end
  end

  // Outside SEND the shift register may already hold the next number, so the
  // bus shows the held copy instead.
  assign digitValid = (state_q == S_SEND);
  assign digitOut   = digitValid ? top_digit : digit_q;
  assign asciiOut   = 8'h30 + {4'h0, digitOut};
  assign lastDigit  = digitValid && (remaining_q == CNT_W'(1));
  assign busy       = (state_q == S_LOAD) || (state_q == S_SEND);
  assign done       = (state_q == S_DONE);

endmodule

// File: doc/number_reader.md
Name: number_reader

Overview:
- Reader side of the keypad number store.
- On `start`, captures a packed-BCD number of up to NUM_DIGITS digits plus its digit count.
- Streams the digits out one per handshake, most-significant digit first, as raw BCD and ASCII.
- Feeds the LCD/display writer and the operand-transfer path of the ARM calculator.

Parameters:
- NUM_DIGITS, 10: maximum digits held; numberIn width is 4*NUM_DIGITS.
- CNT_W, 4: width of countIn; must satisfy 2^CNT_W > NUM_DIGITS.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to capture and stream the number; level-sampled in IDLE only.
- abort  input  1  synchronous cancel of the current stream.
- numberIn  input  4*NUM_DIGITS  packed BCD; digit 0 in bits [3:0].
- countIn  input  CNT_W  number of valid digits in numberIn.
- digitReady  input  1  consumer accepts digitOut this cycle.
- digitOut  output  4  current BCD digit.
- asciiOut  output  8  8'h30 + digitOut.
- digitValid  output  1  digitOut/asciiOut/lastDigit are valid.
- lastDigit  output  1  current digit is the final one of the stream.
- busy  output  1  a stream is in progress (states LOAD/SEND).
- done  output  1  one-cycle pulse after the last digit is accepted.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; digitOut=0; asciiOut=8'h30; digitValid=0; lastDigit=0; busy=0; done=0; shift register and remaining-count cleared. Reset mid-stream abandons the stream with no done pulse.
- States: IDLE, LOAD, SEND, DONE.
- IDLE:
  - If start=1 at a posedge, capture numberIn and eff = (countIn==0) ? 1 : min(countIn, NUM_DIGITS).
  - Go to LOAD.
- LOAD (1 cycle):
  - Left-align: shiftReg = captured << 4*(NUM_DIGITS-eff); remaining = eff.
  - Go to SEND. busy=1.
  - digitValid first asserts 2 cycles after the start edge.
- SEND:
  - digitValid=1; digitOut = shiftReg top nibble; lastDigit = (remaining==1).
  - Outputs are held stable while digitValid=1 and digitReady=0.
  - Transfer occurs at a posedge with digitValid & digitReady: shift left by 4, remaining-1.
  - If the transferred digit was last, go to DONE (digitValid=0 next cycle).
  - One digit maximum per cycle; with digitReady held high, a digit is accepted every cycle.
- DONE (1 cycle):
  - done=1, busy=0, digitValid=0; return to IDLE.
  - start is ignored in DONE. A start still high in the following IDLE cycle begins a new stream.
- abort:
  - Valid in LOAD or SEND, with priority over a same-cycle transfer.
  - Next cycle: IDLE, digitValid=0, busy=0, no done pulse. That transfer is not counted.
  - Ignored in IDLE/DONE.
- start while busy: ignored; no recapture.
- Out-of-range nibbles (>9) are passed unchanged. asciiOut is still 8'h30+digit, 8-bit wrap-free (max 8'h3F).
- digitOut and asciiOut retain their last values when digitValid=0.

Optional Feature:
- Macro LEADING_ZERO_SUPPRESS_EN.
- Defined: in LOAD, after alignment, leading zero digits are skipped while remaining>1. The extra shifting adds at most one cycle per skipped digit before the first digitValid, and at least one digit is always emitted.
- Undefined: all eff digits are emitted, including leading zeros, with LOAD fixed at 1 cycle.

Test Plan:
- numberIn=0x829, countIn=3, digitReady=1 -> digits 8,2,9 on consecutive cycles, asciiOut 0x38,0x32,0x39; lastDigit only with 9; done one cycle after 9 is accepted; busy low with done.
- Same number, digitReady low for 3 cycles on digit 2 -> digitOut=2 and digitValid held stable for those 3 cycles, then 9 follows; total transfers=3.
- countIn=0, numberIn=0 -> single digit 0 with lastDigit=1; countIn=12 with numberIn=0x1234567890 -> exactly 10 digits 1..9,0.
- abort asserted during the 2nd digit of 0x829 -> digitValid low next cycle, no done pulse; next start streams 8,2,9 from the beginning. rst_n low mid-stream -> all outputs at reset values immediately.
- numberIn=0x0007, countIn=4 -> with LEADING_ZERO_SUPPRESS_EN: single digit 7, lastDigit=1; without: 0,0,0,7.
- start held high continuously with 0x829/3 -> streams repeat, each separated by DONE plus IDLE cycles; start during SEND never recaptures.
